// File: rtl/ahb_slave_if.sv
// AHB slave front end of the AHB-to-APB bridge: qualifies and decodes transfers,
// pipelines address/data/direction and generates the two-cycle ERROR response.
module ahb_slave_if #(
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
  parameter logic [31:0] SLV_MASK  = 32'hFC00_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             Hclk,
  input  logic             Hreset,
  input  logic             Hwrite,
  input  logic             Hreadyin,
  input  logic [1:0]       Htrans,
  input  logic [31:0]      Haddr,
  input  logic [31:0]      Hwdata,
  input  logic             Hready_bridge,
  input  logic [31:0]      Prdata,
  output logic             valid,
  output logic [2:0]       tempselx,
  output logic [31:0]      Haddr1,
  output logic [31:0]      Haddr2,
  output logic [31:0]      Hwdata1,
  output logic [31:0]      Hwdata2,
  output logic             Hwrite_reg,
  output logic             Hwrite_reg1,
  output logic             Hreadyout,
  output logic [1:0]       Hresp,
  output logic [31:0]      Hrdata,
  output logic [CNT_W-1:0] xfer_count,
  output logic [7:0]       err_count
);

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} state_t;

  state_t r_state;
  state_t w_next;
  logic   w_active;
  logic   w_unmapped;

  assign w_active   = Hreadyin & ((Htrans == TR_NONSEQ) | (Htrans == TR_SEQ));
  assign w_unmapped = (tempselx == 3'b000);

  // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
  always_comb begin
    tempselx = 3'b000;
    if      ((Haddr & SLV_MASK) == SLV0_BASE) tempselx = 3'b001;
    else if ((Haddr & SLV_MASK) == SLV1_BASE) tempselx = 3'b010;
    else if ((Haddr & SLV_MASK) == SLV2_BASE) tempselx = 3'b100;
  end

  assign valid  = w_active & ~w_unmapped & (r_state == S_OKAY);
  assign Hrdata = Prdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) r_state <= S_OKAY;
    else        r_state <= w_next;
  end

  // Error path is taken regardless of Hready_bridge; S_ERR2 ignores new transfers.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OKAY:  if (w_active && w_unmapped) w_next = S_ERR1;
      S_ERR1:  w_next = S_ERR2;
      S_ERR2:  w_next = S_OKAY;
      default: w_next = S_OKAY;
    endcase
  end

  always_comb begin
    Hreadyout = Hready_bridge;
    Hresp     = RESP_OKAY;
    case (r_state)
      S_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = RESP_ERR;
      end
      S_ERR2: begin
        Hreadyout = 1'b1;
        Hresp     = RESP_ERR;
      end
      default: ;
    endcase
  end

  // Write data trails its address by one cycle, so Hwdata1 lines up with Haddr2.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      Haddr1      <= '0;
      Haddr2      <= '0;
      Hwdata1     <= '0;
      Hwdata2     <= '0;
      Hwrite_reg  <= 1'b0;
      Hwrite_reg1 <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1      <= Haddr;
      Haddr2      <= Haddr1;
      Hwdata1     <= Hwdata;
      Hwdata2     <= Hwdata1;
      Hwrite_reg  <= Hwrite;
      Hwrite_reg1 <= Hwrite_reg;
    end
  end

  // Transfer count wraps; error count saturates.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      xfer_count <= '0;
      err_count  <= '0;
    end else begin
      if (valid && Hreadyout) xfer_count <= xfer_count + 1'b1;
      if ((r_state == S_OKAY) && (w_next == S_ERR1) && (err_count != 8'hFF))
        err_count <= err_count + 1'b1;
    end
  end

endmodule
